// File: rtl/pkg_botones.sv
// Shared definitions for the button-press detectors: FSM state encoding and default timing.
// Defaults assume a 12 MHz clock: 1 s long-press threshold, 200 ms auto-repeat.
package pkg_botones;

    typedef enum logic [1:0] {
        REPOSO     = 2'd0,
        PRESIONADO = 2'd1,
        LARGO      = 2'd2
    } estado_t;

    localparam int T_LARGO_DEF   = 12_000_000;
    localparam int T_REPETIR_DEF = 2_400_000;
    localparam int ANCHO_CNT_DEF = 24;

endpackage

// File: rtl/detector_flanco.sv
// Registers the button level once and flags rising/falling edges against that copy.
// Edges are combinational from the current input; no backpressure.
module detector_flanco
    import pkg_botones::*;
(
    input  logic clk,
    input  logic rst,
    input  logic boton_i,
    output logic subida_o,
    output logic bajada_o
);

    logic b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q <= 1'b0;
        end else begin
            b_q <= boton_i;
        end
    end

    assign subida_o = boton_i & ~b_q;
    assign bajada_o = ~boton_i & b_q;

endmodule

// File: rtl/detector_pulsacion.sv
// Classifies button presses into short/long with auto-repeat while held.
// All outputs registered, pulses appear one cycle after the detecting edge; no backpressure.
module detector_pulsacion #(
    parameter int T_LARGO   = pkg_botones::T_LARGO_DEF,
    parameter int T_REPETIR = pkg_botones::T_REPETIR_DEF,
    parameter int ANCHO_CNT = pkg_botones::ANCHO_CNT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic boton,
    output logic pulsado,
    output logic soltado,
    output logic corto,
    output logic largo,
    output logic repetir,
    output logic mantenido
);

    import pkg_botones::*;

    localparam longint LIMITE = longint'(1) << ANCHO_CNT;

    generate
        if (T_LARGO < 2 || T_REPETIR < 2 ||
            longint'(T_LARGO) > LIMITE || longint'(T_REPETIR) > LIMITE) begin : g_param_invalidos
            $error("detector_pulsacion: T_LARGO/T_REPETIR must be >= 2 and <= 2**ANCHO_CNT");
        end
    endgenerate

    localparam logic [ANCHO_CNT-1:0] FIN_LARGO   = ANCHO_CNT'(T_LARGO - 1);
    localparam logic [ANCHO_CNT-1:0] FIN_REPETIR = ANCHO_CNT'(T_REPETIR - 1);

    logic                 subida;
    logic                 bajada;
    estado_t              estado_q;
    logic [ANCHO_CNT-1:0] cnt_q;
    logic                 pulsado_q;
    logic                 soltado_q;
    logic                 corto_q;
    logic                 largo_q;
    logic                 repetir_q;
    logic                 mantenido_q;

    detector_flanco u_flanco (
        .clk      (clk),
        .rst      (rst),
        .boton_i  (boton),
        .subida_o (subida),
        .bajada_o (bajada)
    );

    // Release is tested before any terminal count so it always wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q    <= REPOSO;
            cnt_q       <= '0;
            pulsado_q   <= 1'b0;
            soltado_q   <= 1'b0;
            corto_q     <= 1'b0;
            largo_q     <= 1'b0;
            repetir_q   <= 1'b0;
            mantenido_q <= 1'b0;
        end else begin
            pulsado_q <= 1'b0;
            soltado_q <= 1'b0;
            corto_q   <= 1'b0;
            largo_q   <= 1'b0;
            repetir_q <= 1'b0;
            case (estado_q)
                REPOSO: begin
                    mantenido_q <= 1'b0;
                    if (subida) begin
                        pulsado_q <= 1'b1;
                        cnt_q     <= '0;
                        estado_q  <= PRESIONADO;
                    end
                end
                PRESIONADO: begin
                    if (bajada) begin
                        soltado_q <= 1'b1;
                        corto_q   <= 1'b1;
                        estado_q  <= REPOSO;
                    end else if (cnt_q == FIN_LARGO) begin
                        largo_q     <= 1'b1;
                        mantenido_q <= 1'b1;
                        cnt_q       <= '0;
                        estado_q    <= LARGO;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                LARGO: begin
                    if (bajada) begin
                        soltado_q   <= 1'b1;
                        mantenido_q <= 1'b0;
                        estado_q    <= REPOSO;
                    end else if (cnt_q == FIN_REPETIR) begin
                        repetir_q <= 1'b1;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    mantenido_q <= 1'b0;
                    cnt_q       <= '0;
                    estado_q    <= REPOSO;
                end
            endcase
        end
    end

    assign pulsado   = pulsado_q;
    assign soltado   = soltado_q;
    assign corto     = corto_q;
    assign largo     = largo_q;
    assign repetir   = repetir_q;
    assign mantenido = mantenido_q;

endmodule

// File: doc/detector_pulsacion.md
DETECTOR_PULSACION -- requirements
Module: detector_pulsacion

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all other logic SHALL be synchronous to the clock.
REQ-002 Parameter T_LARGO, default 12_000_000, SHALL set the long-press threshold in clk cycles (1 s at 12 MHz).
REQ-003 Parameter T_REPETIR, default 2_400_000, SHALL set the auto-repeat period in clk cycles (200 ms at 12 MHz).
REQ-004 Parameter ANCHO_CNT, default 24, SHALL set the counter width in bits.
REQ-005 Port clk, input, 1 bit: system clock.
REQ-006 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 Port boton, input, 1 bit: debounced active-high button level, already synchronous to clk.
REQ-008 Port pulsado, output, 1 bit: one-cycle pulse on press.
REQ-009 Port soltado, output, 1 bit: one-cycle pulse on release.
REQ-010 Port corto, output, 1 bit: one-cycle pulse on release of a press shorter than T_LARGO.
REQ-011 Port largo, output, 1 bit: one-cycle pulse when a hold reaches T_LARGO.
REQ-012 Port repetir, output, 1 bit: one-cycle pulse every T_REPETIR cycles after largo while held.
REQ-013 Port mantenido, output, 1 bit: level, high while in state LARGO.

Function
REQ-014 boton SHALL be registered once into b_q; a rising edge is boton=1 with b_q=0 at a clk edge, and a falling edge is boton=0 with b_q=1.
REQ-015 All outputs SHALL be registered, and each pulse SHALL be visible in the cycle after the clk edge that detected its condition.
REQ-016 The FSM states SHALL be REPOSO, PRESIONADO and LARGO.
REQ-017 REPOSO on a rising edge: assert pulsado, clear cnt, go to PRESIONADO.
REQ-018 PRESIONADO with boton=1: increment cnt; at the edge where cnt==T_LARGO-1, assert largo, clear cnt, go to LARGO.
REQ-019 PRESIONADO on a falling edge: assert soltado and corto, go to REPOSO, no largo.
REQ-020 A falling edge on the same clk edge as cnt==T_LARGO-1 SHALL take priority: corto and soltado are asserted, largo is not.
REQ-021 LARGO with boton=1: increment cnt; at cnt==T_REPETIR-1, assert repetir and clear cnt.
REQ-022 A release in LARGO SHALL beat a simultaneous repeat terminal count.
REQ-023 LARGO on a falling edge: assert soltado only (no corto, no repetir), go to REPOSO.
REQ-024 Resulting timing: largo occurs exactly T_LARGO cycles after pulsado; the first repetir occurs T_REPETIR cycles after largo, then every T_REPETIR cycles.
REQ-025 mantenido SHALL be high in every cycle the FSM is in LARGO, and low otherwise.
REQ-026 cnt SHALL be ANCHO_CNT bits unsigned; because it is cleared at each terminal count, it SHALL never wrap.
REQ-027 Elaboration SHALL fail if T_LARGO<2, if T_REPETIR<2, or if either exceeds 2^ANCHO_CNT.
REQ-028 pulsado and soltado SHALL never be asserted in the same cycle.
REQ-029 At most one of corto, largo and repetir SHALL be asserted per cycle.

Reset
REQ-030 rst=1 SHALL immediately force state REPOSO, cnt=0, b_q=0 and every output to 0, independent of clk.
REQ-031 If boton=1 when rst deasserts, the first clk edge SHALL detect a rising edge and produce pulsado.
REQ-032 A reset asserted mid-press SHALL emit no soltado or corto.

Structure
REQ-033 Shared package pkg_botones SHALL hold the FSM state encoding and the default timing constants (T_LARGO, T_REPETIR, ANCHO_CNT).
REQ-034 Edge detection (b_q register with rise/fall outputs) SHALL be a sub-module named detector_flanco.
REQ-035 The FSM and counter SHALL remain in the top level of this block.

Verification (T_LARGO=8, T_REPETIR=3, ANCHO_CNT=4)
REQ-036 Reset test: rst=1 with boton=1 -> all outputs 0; rst falls -> pulsado on the first cycle after the next clk edge.
REQ-037 Short press: boton high 5 cycles, then low -> pulsado, then corto+soltado together 1 cycle after the falling edge is sampled; largo never asserts.
REQ-038 Long press with repeat: boton held 16 cycles -> largo 8 cycles after pulsado, mantenido rises with it, repetir at +3 and +6 after largo; on release, soltado only and mantenido falls.
REQ-039 Boundary: falling edge sampled on the same edge as cnt==7 -> corto+soltado asserted, largo not asserted.
REQ-040 Reset mid-operation: rst pulsed while in LARGO -> mantenido and all pulses drop asynchronously, and no soltado follows.
REQ-041 Assertions: the exclusivity rules of REQ-028 and REQ-029 SHALL be checked in every cycle of every scenario.
